// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave: accepts one load/store at a time over req/ack,
// inserts LATENCY wait states, then acknowledges for one cycle with data or fault.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int AW      = $clog2(DEPTH),
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstDM,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  // state  | meaning
  // S_IDLE | waiting for req; accepts and latches the request
  // S_WAIT | counting down wait states
  // S_RESP | ack high for one cycle; store commits on the edge leaving
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [DEPTH];

  logic          enter_resp;
  logic [31:0]   eff_addr;
  logic          eff_we;
  logic          eff_fault;
  logic [AW-1:0] eff_idx;
  logic          mem_we;
  logic [AW-1:0] wr_idx;

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    enter_resp = 1'b0;

    // With LATENCY=0 the response is formed on the accept edge itself, so the
    // raw inputs are used instead of the not-yet-latched copies.
    eff_addr  = (state_q == S_IDLE) ? addr : addr_q;
    eff_we    = (state_q == S_IDLE) ? we : we_q;
    eff_idx   = eff_addr[AW+1:2];
    eff_fault = is_fault(eff_addr);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          cnt_d   = LAT;
          if (LAT == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = '0;
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enter_resp) begin
      ack_d   = 1'b1;
      err_d   = eff_fault;
      rdata_d = (eff_we || eff_fault) ? 32'h0 : mem_q[eff_idx];
    end

    mem_we = (state_q == S_RESP) && we_q && !is_fault(addr_q);
    wr_idx = addr_q[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (rstDM) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (mem_we) begin
        mem_q[wr_idx] <= wdata_q;
      end
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE) || req;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance for the main
// sequence and one LATENCY=0 instance for back-to-back held-req traffic.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req2, we2, ack2, err2, busy2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        req0, we0, ack0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rstDM(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ack(ack2), .rdata(rdata2), .err(err2), .busy(busy2)
  );

  data_mem_responder #(.DEPTH(1024), .AW(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rstDM(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request on the LATENCY=2 instance; cycle 0 is the request cycle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit churn, output logic [31:0] rd, output logic e,
                     output int ack_cyc, output int busy_n,
                     output logic busy_after, output logic ack_after);
    @(posedge clk); #1;
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    ack_cyc = -1; busy_n = 0; rd = '0; e = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy2) busy_n++;
      if (ack2) begin
        ack_cyc = k; rd = rdata2; e = err2;
        break;
      end
      @(posedge clk); #1;
      if (churn && k == 0) begin
        addr2 = 32'h20; wdata2 = 32'h1234;
      end
    end
    @(posedge clk); #1;
    req2 = 1'b0; we2 = 1'b0;
    @(negedge clk);
    busy_after = busy2;
    ack_after  = ack2;
  endtask

  logic [31:0] rd;
  logic        e, ba, aa;
  int          cyc, bn, acks;
  logic [7:0]  ack_seq;
  logic [31:0] rd_c3, rd_c5;

  initial begin
    rst = 1'b1;
    req2 = 0; we2 = 0; addr2 = '0; wdata2 = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(ack2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_rdata", rdata2, 32'h0);
    chk("rst_busy", 32'(busy2), 32'd0);

    txn(1'b0, 32'h0, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("ld0_rdata", rd, 32'h0);
    chk("ld0_cyc", 32'(cyc), 32'd3);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, e, cyc, bn, ba, aa);
    chk("st10_cyc", 32'(cyc), 32'd3);
    chk("st10_err", 32'(e), 32'd0);
    chk("st10_busy", 32'(bn), 32'd4);
    chk("st10_busy_after", 32'(ba), 32'd0);
    chk("st10_ack_after", 32'(aa), 32'd0);

    txn(1'b0, 32'h10, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("ld10_rdata", rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(e), 32'd0);
    chk("ld10_busy", 32'(bn), 32'd4);

    txn(1'b1, 32'h13, 32'h00000BAD, 0, rd, e, cyc, bn, ba, aa);
    chk("st13_err", 32'(e), 32'd1);
    chk("st13_cyc", 32'(cyc), 32'd3);
    txn(1'b0, 32'h10, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("ld10_after_fault", rd, 32'hDEADBEEF);

    txn(1'b0, 32'h00001000, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("ld1000_err", 32'(e), 32'd1);
    chk("ld1000_rdata", rd, 32'h0);

    txn(1'b1, 32'h30, 32'hCAFEF00D, 1, rd, e, cyc, bn, ba, aa);
    chk("churn_cyc", 32'(cyc), 32'd3);
    txn(1'b0, 32'h30, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("churn_ld30", rd, 32'hCAFEF00D);
    txn(1'b0, 32'h20, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("churn_ld20", rd, 32'h0);

    // Reset lands while the store to 0x8 sits in WAIT.
    @(posedge clk); #1;
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h8; wdata2 = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1; req2 = 1'b0; we2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack2) acks++;
    end
    chk("midrst_no_ack", 32'(acks), 32'd0);
    chk("midrst_busy", 32'(busy2), 32'd0);
    txn(1'b0, 32'h8, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("midrst_ld8", rd, 32'h0);
    chk("midrst_ld8_cyc", 32'(cyc), 32'd3);
    txn(1'b0, 32'h10, 32'h0, 0, rd, e, cyc, bn, ba, aa);
    chk("midrst_mem_cleared", rd, 32'h0);

    // LATENCY=0: req held high, store then load to the same word.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hA5A5A5A5;
    ack_seq = '0; rd_c3 = '0; rd_c5 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ack_seq[k] = ack0;
      if (k == 3) rd_c3 = rdata0;
      if (k == 5) rd_c5 = rdata0;
      @(posedge clk); #1;
      if (k == 1) we0 = 1'b0;
    end
    req0 = 1'b0;
    chk("lat0_ack_seq", 32'(ack_seq), 32'h000000AA);
    chk("lat0_raw_rdata", rd_c3, 32'hA5A5A5A5);
    chk("lat0_ld2_rdata", rd_c5, 32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk);
    chk("lat0_idle_busy", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
